framebuffer_write_arbiter: RTL and testbench
============================================

FRAMEBUFFER_WRITE_ARBITER -- requirements
Module: framebuffer_write_arbiter

Interface
REQ-001 SHALL have parameter BYTES_PER_PIXEL, default params_pkg::BYTES_PER_PIXEL, bytes per pixel.
REQ-002 SHALL have parameter PIXEL_HEIGHT, default params_pkg::PIXEL_HEIGHT, panel rows.
REQ-003 SHALL have parameter PIXEL_WIDTH, default params_pkg::PIXEL_WIDTH, panel columns.
REQ-004 SHALL have parameter NUM_REQ, default 2, requester count, legal range 2..4.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit.
REQ-006 SHALL have the following ports. RB = calc_pkg::num_row_address_bits(PIXEL_HEIGHT). CB = calc_pkg::num_column_address_bits(PIXEL_WIDTH). PB = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL). Bus field i of every packed request port belongs to requester i.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_access_start  in  NUM_REQ  per-requester transaction-start pulse.
- req_done  in  NUM_REQ  per-requester transaction-end pulse.
- req_write_enable  in  NUM_REQ  per-requester byte-write strobe.
- req_row  in  NUM_REQ*RB  row addresses.
- req_column  in  NUM_REQ*CB  column addresses.
- req_pixel  in  NUM_REQ*PB  pixel byte selects.
- req_data  in  NUM_REQ*8  write data.
- grant  out  NUM_REQ  one-hot ownership; all-zero when idle.
- ram_row  out  RB  muxed row.
- ram_column  out  CB  muxed column.
- ram_pixel  out  PB  muxed pixel.
- ram_data  out  8  muxed data.
- ram_write_enable  out  1  gated write strobe.
- dropped_write  out  1  sticky flag: a non-granted requester asserted write_enable.
- timeout_err  out  1  sticky flag: watchdog fired; present only under FB_ARB_TIMEOUT_EN, otherwise tied 0.

Function
REQ-007 SHALL use states IDLE and OWNED; OWNED carries a registered owner index.
REQ-008 SHALL keep a pending bit per requester, set the cycle after that requester's req_access_start pulse.
REQ-009 SHALL, in IDLE with any pending bit set, select the first pending index at or after rr_ptr, with wrap-around modulo NUM_REQ.
REQ-010 SHALL, on that selection, enter OWNED and assert grant one cycle after the selection, then clear that requester's pending bit.
REQ-011 SHALL give a worst-case start latency of 2 clk cycles from req_access_start to grant when IDLE.
REQ-012 SHALL, in OWNED, drive ram_row, ram_column, ram_pixel, ram_data combinationally from the owner's fields.
REQ-013 SHALL, in OWNED, drive ram_write_enable equal to the owner's req_write_enable.
REQ-014 SHALL, in IDLE, drive ram_write_enable 0 and hold the other ram_* outputs at their last value.
REQ-015 SHALL, on the owner's req_done, return to IDLE on the next edge, clear grant, and set rr_ptr to (owner+1) mod NUM_REQ.
REQ-016 SHALL never go from one grant directly to another; an IDLE cycle always separates them.
REQ-017 SHALL ignore req_access_start from the current owner while OWNED; it SHALL NOT set pending.
REQ-018 SHALL set the owner's pending bit again if req_done and req_access_start from the owner coincide.
REQ-019 SHALL ignore req_done from any non-owner.
REQ-020 SHALL never forward req_write_enable from a non-owner, and SHALL set dropped_write when one occurs.
REQ-021 SHALL set pending bits for simultaneous starts from several requesters in the same cycle; round-robin then serves them in turn.

Reset
REQ-022 SHALL, while reset_n=0 (asynchronous), force state IDLE, grant 0, pending 0, and rr_ptr 0.
REQ-023 SHALL, while reset_n=0, force all ram_* outputs 0, dropped_write 0, timeout_err 0, and the watchdog counter 0.
REQ-024 SHALL abandon a transaction that is in flight when reset_n asserts, with no further write_enable forwarded.

Configuration
REQ-025 SHALL, with FB_ARB_TIMEOUT_EN defined, count clk cycles in OWNED and reset the count on each new grant.
REQ-026 SHALL, with FB_ARB_TIMEOUT_EN defined, on count reaching TIMEOUT_CYCLES with no owner req_done: force IDLE, advance rr_ptr as for a normal done, and set timeout_err.
REQ-027 SHALL, without FB_ARB_TIMEOUT_EN, omit the counter, hold ownership indefinitely, and tie timeout_err 0.

Verification
REQ-028 SHALL cover: req0 start, 3 writes (row 2, col 5, pixel 0..2, data 8'hA1..8'hA3), done -> grant=01 within 2 cycles, exactly 3 ram_write_enable pulses with matching address/data, grant=00 after done.
REQ-029 SHALL cover: req0 and req1 start in the same cycle, rr_ptr=0 -> req0 served first, then IDLE for 1 cycle, then req1; rr_ptr=0 after both.
REQ-030 SHALL cover: req1 asserts write_enable while req0 owns -> ram_write_enable follows req0 only, dropped_write=1 and stays 1 until reset.
REQ-031 SHALL cover: reset_n pulled low mid-transaction after 2 of 4 writes -> grant=00 and ram_write_enable=0 immediately; no further writes after release.
REQ-032 SHALL cover, with FB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner never sends done -> grant drops after 16 cycles, timeout_err=1, pending req1 granted next.

Source files
------------

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter granting one requester at a time exclusive write access to the framebuffer RAM.
// Optional ownership watchdog is enabled by defining FB_ARB_TIMEOUT_EN.

package params_pkg;
  localparam int BYTES_PER_PIXEL = 3;
  localparam int PIXEL_HEIGHT    = 32;
  localparam int PIXEL_WIDTH     = 64;
endpackage

package calc_pkg;
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int num_row_address_bits(input int pixel_height);
    return clog2_min1(pixel_height);
  endfunction

  function automatic int num_column_address_bits(input int pixel_width);
    return clog2_min1(pixel_width);
  endfunction

  function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
    return clog2_min1(bytes_per_pixel);
  endfunction
endpackage

module framebuffer_write_arbiter #(
  parameter int BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
  parameter int PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
  parameter int PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
  parameter int NUM_REQ         = 2,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int RB = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
  localparam int CB = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int PB = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_access_start,
  input  logic [NUM_REQ-1:0]    req_done,
  input  logic [NUM_REQ-1:0]    req_write_enable,
  input  logic [NUM_REQ*RB-1:0] req_row,
  input  logic [NUM_REQ*CB-1:0] req_column,
  input  logic [NUM_REQ*PB-1:0] req_pixel,
  input  logic [NUM_REQ*8-1:0]  req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [RB-1:0]         ram_row,
  output logic [CB-1:0]         ram_column,
  output logic [PB-1:0]         ram_pixel,
  output logic [7:0]            ram_data,
  output logic                  ram_write_enable,
  output logic                  dropped_write,
  output logic                  timeout_err
);

  localparam int OW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("framebuffer_write_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t               state_reg, state_next;
  logic [OW-1:0]        owner_reg, owner_next;
  logic [OW-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [NUM_REQ-1:0]   pending_reg, pending_next;
  logic                 dropped_reg, dropped_next;
  logic [RB-1:0]        row_hold_reg;
  logic [CB-1:0]        column_hold_reg;
  logic [PB-1:0]        pixel_hold_reg;
  logic [7:0]           data_hold_reg;

  logic                 sel_found;
  logic [OW-1:0]        sel_idx;
  logic [OW-1:0]        owner_succ;
  logic                 owner_done;
  logic                 owned;

  logic [RB-1:0]        row_a    [NUM_REQ];
  logic [CB-1:0]        column_a [NUM_REQ];
  logic [PB-1:0]        pixel_a  [NUM_REQ];
  logic [7:0]           data_a   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fields
    assign row_a[gi]    = req_row[gi*RB +: RB];
    assign column_a[gi] = req_column[gi*CB +: CB];
    assign pixel_a[gi]  = req_pixel[gi*PB +: PB];
    assign data_a[gi]   = req_data[gi*8 +: 8];
  end

  assign owned      = (state_reg == OWNED);
  assign owner_done = req_done[owner_reg];
  assign owner_succ = (owner_reg == OW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin : p_select
    int            cand;
    logic [OW-1:0] cand_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(rr_ptr_reg) + k) % NUM_REQ;
      cand_idx = OW'(cand);
      if (!sel_found && pending_reg[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

`ifdef FB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count_reg, count_next;
  logic          timeout_reg, timeout_next;
`endif

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    rr_ptr_next  = rr_ptr_reg;
    pending_next = pending_reg | req_access_start;
`ifdef FB_ARB_TIMEOUT_EN
    count_next   = count_reg;
    timeout_next = timeout_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next            = OWNED;
          owner_next            = sel_idx;
          pending_next[sel_idx] = 1'b0;
`ifdef FB_ARB_TIMEOUT_EN
          count_next            = '0;
`endif
        end
      end
      OWNED: begin
        if (owner_done) begin
          // A start coinciding with done re-queues the owner.
          state_next  = IDLE;
          rr_ptr_next = owner_succ;
        end
`ifdef FB_ARB_TIMEOUT_EN
        else if (count_reg == CW'(TIMEOUT_CYCLES - 1)) begin
          state_next              = IDLE;
          rr_ptr_next             = owner_succ;
          timeout_next            = 1'b1;
          pending_next[owner_reg] = pending_reg[owner_reg];
        end
`endif
        else begin
          pending_next[owner_reg] = pending_reg[owner_reg];
        end
`ifdef FB_ARB_TIMEOUT_EN
        count_next = count_reg + 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  assign dropped_next = dropped_reg | (|(req_write_enable & ~grant));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      rr_ptr_reg      <= '0;
      pending_reg     <= '0;
      dropped_reg     <= 1'b0;
      row_hold_reg    <= '0;
      column_hold_reg <= '0;
      pixel_hold_reg  <= '0;
      data_hold_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      rr_ptr_reg  <= rr_ptr_next;
      pending_reg <= pending_next;
      dropped_reg <= dropped_next;
      if (owned) begin
        row_hold_reg    <= row_a[owner_reg];
        column_hold_reg <= column_a[owner_reg];
        pixel_hold_reg  <= pixel_a[owner_reg];
        data_hold_reg   <= data_a[owner_reg];
      end
    end
  end

`ifdef FB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      timeout_reg <= timeout_next;
    end
  end
  assign timeout_err = timeout_reg;
`else
  assign timeout_err = 1'b0;
`endif

  assign grant            = owned ? (NUM_REQ'(1) << owner_reg) : '0;
  assign ram_write_enable = owned & req_write_enable[owner_reg];
  assign dropped_write    = dropped_reg;

  // IDLE presents the values captured during the last owned cycle.
  always_comb begin
    if (owned) begin
      ram_row    = row_a[owner_reg];
      ram_column = column_a[owner_reg];
      ram_pixel  = pixel_a[owner_reg];
      ram_data   = data_a[owner_reg];
    end else begin
      ram_row    = row_hold_reg;
      ram_column = column_hold_reg;
      ram_pixel  = pixel_hold_reg;
      ram_data   = data_hold_reg;
    end
  end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Scoreboard bench for framebuffer_write_arbiter: directed scenarios plus randomized multi-requester batches.
module tb_framebuffer_write_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;
  localparam int RB = calc_pkg::num_row_address_bits(params_pkg::PIXEL_HEIGHT);
  localparam int CB = calc_pkg::num_column_address_bits(params_pkg::PIXEL_WIDTH);
  localparam int PB = calc_pkg::num_pixelcolorselect_bits(params_pkg::BYTES_PER_PIXEL);
  localparam int FW = RB + CB + PB + 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req_access_start = '0;
  logic [N-1:0]  req_done = '0;
  logic [N-1:0]  req_write_enable = '0;
  logic [N*RB-1:0] req_row = '0;
  logic [N*CB-1:0] req_column = '0;
  logic [N*PB-1:0] req_pixel = '0;
  logic [N*8-1:0]  req_data = '0;
  logic [N-1:0]  grant;
  logic [RB-1:0] ram_row;
  logic [CB-1:0] ram_column;
  logic [PB-1:0] ram_pixel;
  logic [7:0]    ram_data;
  logic          ram_write_enable;
  logic          dropped_write;
  logic          timeout_err;

  framebuffer_write_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_access_start(req_access_start), .req_done(req_done),
    .req_write_enable(req_write_enable),
    .req_row(req_row), .req_column(req_column), .req_pixel(req_pixel), .req_data(req_data),
    .grant(grant), .ram_row(ram_row), .ram_column(ram_column), .ram_pixel(ram_pixel),
    .ram_data(ram_data), .ram_write_enable(ram_write_enable),
    .dropped_write(dropped_write), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] mon_got, mon_exp;
  logic [FW-1:0] last_fields;
  int  exp_rr = 0;
  bit  exp_dropped = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Every forwarded write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (ram_write_enable !== 1'b0) begin
      mon_got = {ram_row, ram_column, ram_pixel, ram_data};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got 0x%0h, expected no write", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL write_fields: got 0x%0h, expected 0x%0h", mon_got, mon_exp);
        end else begin
          $display("[TB] write ok fields=0x%0h", mon_got);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_access_start = '0; req_done = '0; req_write_enable = '0;
    tick(); tick();
    check("reset_grant", 64'(grant), 64'd0);
    check("reset_ram_fields", 64'({ram_row, ram_column, ram_pixel, ram_data}), 64'd0);
    check("reset_ram_we", 64'(ram_write_enable), 64'd0);
    check("reset_dropped", 64'(dropped_write), 64'd0);
    check("reset_timeout", 64'(timeout_err), 64'd0);
    reset_n = 1'b1;
    tick();
    exp_rr = 0;
    exp_dropped = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_mask(input logic [N-1:0] m);
    req_access_start = m;
    tick();
    req_access_start = '0;
  endtask

  task automatic wait_grant(input int idx, input bit chk_lat);
    int lat;
    lat = 1;
    while (grant == '0 && lat < 60) begin
      tick();
      lat++;
    end
    check("grant_owner", 64'(grant), 64'(1) << idx);
    if (chk_lat) check("start_latency_le2", 64'(lat <= 2), 64'd1);
    $display("[TB] grant to req%0d after %0d cycles", idx, lat);
  endtask

  task automatic do_write(input int idx, input logic [RB-1:0] row, input logic [CB-1:0] col,
                          input logic [PB-1:0] pix, input logic [7:0] data, input bit inject);
    int o;
    req_row[idx*RB +: RB] = row;
    req_column[idx*CB +: CB] = col;
    req_pixel[idx*PB +: PB] = pix;
    req_data[idx*8 +: 8] = data;
    req_write_enable[idx] = 1'b1;
    if (inject) begin
      o = (idx + 1 + $urandom_range(0, N - 2)) % N;
      req_row[o*RB +: RB] = RB'($urandom);
      req_column[o*CB +: CB] = CB'($urandom);
      req_pixel[o*PB +: PB] = PB'($urandom);
      req_data[o*8 +: 8] = 8'($urandom);
      req_write_enable[o] = 1'b1;
      exp_dropped = 1'b1;
    end
    last_fields = {row, col, pix, data};
    exp_q.push_back(last_fields);
    tick();
    req_write_enable = '0;
  endtask

  task automatic finish(input int idx, input bit restart);
    req_done[idx] = 1'b1;
    if (restart) req_access_start[idx] = 1'b1;
    tick();
    req_done = '0;
    req_access_start = '0;
    check("grant_idle_after_done", 64'(grant), 64'd0);
    check("ram_we_idle", 64'(ram_write_enable), 64'd0);
    check("ram_hold_idle", 64'({ram_row, ram_column, ram_pixel, ram_data}), 64'(last_fields));
  endtask

  // mode 0: plain; 1: owner re-start mid-ownership (ignored); 2: start together with done.
  task automatic serve(input int idx, input bit chk_lat, input int mode, input bit rand_drop);
    int nw;
    wait_grant(idx, chk_lat);
    nw = $urandom_range(1, 4);
    for (int w = 0; w < nw; w++) begin
      do_write(idx, RB'($urandom), CB'($urandom), PB'($urandom), 8'($urandom),
               rand_drop && ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) tick();
    end
    if (mode == 1) begin
      req_access_start[idx] = 1'b1;
      tick();
      req_access_start = '0;
    end
    finish(idx, mode == 2);
  endtask

  task automatic batch(input logic [N-1:0] mask, input bit rand_modes);
    logic [N-1:0] remaining;
    int ptr, idx, mode, restarts;
    bit first;
    remaining = mask;
    ptr = exp_rr;
    first = 1'b1;
    restarts = 0;
    start_mask(mask);
    while (remaining != '0) begin
      idx = ptr;
      for (int k = 0; k < N; k++) begin
        if (remaining[(ptr + k) % N]) begin
          idx = (ptr + k) % N;
          break;
        end
      end
      mode = rand_modes ? $urandom_range(0, 2) : 0;
      if (mode == 2 && restarts >= 2) mode = 0;
      if (mode == 2) restarts++;
      serve(idx, first, mode, rand_modes);
      first = 1'b0;
      remaining[idx] = (mode == 2);
      ptr = (idx + 1) % N;
    end
    exp_rr = ptr;
    repeat (3) tick();
    check("no_spurious_grant", 64'(grant), 64'd0);
    check("dropped_flag", 64'(dropped_write), 64'(exp_dropped));
  endtask

  initial begin
    int hold;
    last_fields = '0;
    do_reset();

    // Single requester: fixed address, three byte writes.
    start_mask(3'b001);
    wait_grant(0, 1'b1);
    for (int p = 0; p < 3; p++)
      do_write(0, RB'(2), CB'(5), PB'(p), 8'(8'hA1 + p), 1'b0);
    finish(0, 1'b0);
    exp_rr = 1;
    check("req0_writes_consumed", 64'(exp_q.size()), 64'd0);
    check("no_drop_single", 64'(dropped_write), 64'd0);

    // Simultaneous starts from pointer 0.
    do_reset();
    batch(3'b011, 1'b0);

    // Foreign write while req0 owns.
    do_reset();
    start_mask(3'b001);
    wait_grant(0, 1'b1);
    do_write(0, RB'(7), CB'(9), PB'(1), 8'h5C, 1'b1);
    do_write(0, RB'(8), CB'(10), PB'(2), 8'h5D, 1'b0);
    finish(0, 1'b0);
    exp_rr = 1;
    check("dropped_set", 64'(dropped_write), 64'd1);
    repeat (5) tick();
    check("dropped_sticky", 64'(dropped_write), 64'd1);

    // Reset in the middle of a four-write transaction.
    do_reset();
    start_mask(3'b010);
    wait_grant(1, 1'b1);
    do_write(1, RB'(3), CB'(4), PB'(0), 8'h11, 1'b0);
    do_write(1, RB'(3), CB'(4), PB'(1), 8'h12, 1'b0);
    req_write_enable[1] = 1'b1;
    reset_n = 1'b0;
    #1;
    check("midreset_grant", 64'(grant), 64'd0);
    check("midreset_ram_we", 64'(ram_write_enable), 64'd0);
    check("midreset_fields", 64'({ram_row, ram_column, ram_pixel, ram_data}), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();
    req_write_enable = '0;
    check("post_reset_no_grant", 64'(grant), 64'd0);
    check("post_reset_dropped", 64'(dropped_write), 64'd1);
    exp_rr = 0;
    exp_dropped = 1'b1;

`ifdef FB_ARB_TIMEOUT_EN
    do_reset();
    start_mask(3'b001);
    wait_grant(0, 1'b1);
    hold = 1;
    start_mask(3'b010);
    while (grant == 3'b001 && hold < 100) begin
      hold++;
      tick();
    end
    check("timeout_hold_cycles", 64'(hold), 64'(TO));
    check("timeout_err_set", 64'(timeout_err), 64'd1);
    wait_grant(1, 1'b0);
    do_write(1, RB'(1), CB'(1), PB'(1), 8'h77, 1'b0);
    finish(1, 1'b0);
    exp_rr = 2;
    check("timeout_err_sticky", 64'(timeout_err), 64'd1);
`else
    do_reset();
    start_mask(3'b001);
    wait_grant(0, 1'b1);
    repeat (40) tick();
    check("ownership_held", 64'(grant), 64'd1);
    check("timeout_err_tied", 64'(timeout_err), 64'd0);
    do_write(0, RB'(6), CB'(6), PB'(0), 8'h66, 1'b0);
    finish(0, 1'b0);
    exp_rr = 1;
`endif

    // Randomized batches of simultaneous starts.
    for (int b = 0; b < 25; b++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      batch(m, 1'b1);
    end

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
